dcache_arbiter: RTL and testbench

- Shares the single data-cache access port between two requesters: M0 (CPU memory stage) and M1 (debug/DMA loader).
- Issues at most one access per cycle, either a read or a write.
- Routes the fixed-latency read responses back to the requester that issued them.
- Inserts the write-to-read turnaround bubble the cache needs, and keeps M1 from starving under a continuous M0 load.

---
 rtl/dcache_arbiter_pkg.sv | 24 ++
 rtl/dcache_resp_pipe.sv | 34 +++
 rtl/dcache_arbiter.sv | 136 +++++++++++++
 tb/tb_dcache_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arbiter_pkg.sv
// Shared identifiers, access-size codes and response-tag types for the data-cache arbiter.
package dcache_arbiter_pkg;

    localparam logic ARB_ID_M0 = 1'b0;
    localparam logic ARB_ID_M1 = 1'b1;

    localparam int DC_RD_LAT = 2;

    localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
    localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
    localparam logic [2:0] ACCESS_SZ_WORD = 3'd2;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_M0,
        GRANT_M1
    } grant_e;

    typedef struct packed {
        logic valid;
        logic id;
    } rsp_tag_t;

endpackage

// File: rtl/dcache_resp_pipe.sv
// Fixed-depth {valid, id} shift register that follows each cache read to its response cycle.
module dcache_resp_pipe
    import dcache_arbiter_pkg::*;
#(
    parameter int DEPTH = DC_RD_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    rsp_tag_t stage_q [DEPTH];

    // Reset drops every in-flight tag so no response is produced for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= '{valid: in_valid, id: in_id};
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid = stage_q[DEPTH-1].valid;
    assign out_id    = stage_q[DEPTH-1].id;

endmodule

// File: rtl/dcache_arbiter.sv
// Two-requester arbiter for the single data-cache port: write-to-read turnaround,
// M1 anti-starvation and routing of fixed-latency read responses.
module dcache_arbiter
    import dcache_arbiter_pkg::*;
#(
    parameter int RD_LAT     = DC_RD_LAT,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_wsz,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_rhit,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_wsz,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_rhit,
    output logic        dc_re,
    output logic [31:0] dc_raddr,
    output logic        dc_we,
    output logic [31:0] dc_waddr,
    output logic [31:0] dc_wdata,
    output logic [2:0]  dc_wsz,
    input  logic [31:0] dc_rdata,
    input  logic        dc_hit
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             wr_last;
    logic             m0_elig;
    logic             m1_elig;
    grant_e           grant;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [2:0]       sel_wsz;
    logic             granted;
    logic             rsp_valid;
    logic             rsp_id;

    // A read right after an accepted write is held off one cycle; writes stay eligible.
    always_comb begin
        m0_elig = rst_n & m0_req & (m0_we | ~wr_last);
        m1_elig = rst_n & m1_req & (m1_we | ~wr_last);
        grant   = GRANT_NONE;
        if (m1_elig && (starve_cnt == STARVE_LIM)) begin
            grant = GRANT_M1;
        end else if (m0_elig) begin
            grant = GRANT_M0;
        end else if (m1_elig) begin
            grant = GRANT_M1;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wsz   = '0;
        case (grant)
            GRANT_M0: begin
                sel_we    = m0_we;
                sel_addr  = m0_addr;
                sel_wdata = m0_wdata;
                sel_wsz   = m0_wsz;
            end
            GRANT_M1: begin
                sel_we    = m1_we;
                sel_addr  = m1_addr;
                sel_wdata = m1_wdata;
                sel_wsz   = m1_wsz;
            end
            default: begin
            end
        endcase
    end

    assign granted  = (grant != GRANT_NONE);
    assign m0_gnt   = (grant == GRANT_M0);
    assign m1_gnt   = (grant == GRANT_M1);

    assign dc_re    = granted & ~sel_we;
    assign dc_we    = granted & sel_we;
    assign dc_raddr = dc_re ? sel_addr  : '0;
    assign dc_waddr = dc_we ? sel_addr  : '0;
    assign dc_wdata = dc_we ? sel_wdata : '0;
    assign dc_wsz   = dc_we ? sel_wsz   : '0;

    // The counter only tracks an unbroken run of refusals; any idle or granted cycle clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wr_last    <= 1'b0;
        end else begin
            wr_last <= dc_we;
            if (!m1_req || m1_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    dcache_resp_pipe #(
        .DEPTH (RD_LAT)
    ) u_resp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (dc_re),
        .in_id     ((grant == GRANT_M1) ? ARB_ID_M1 : ARB_ID_M0),
        .out_valid (rsp_valid),
        .out_id    (rsp_id)
    );

    assign m0_rvalid = rsp_valid & (rsp_id == ARB_ID_M0);
    assign m1_rvalid = rsp_valid & (rsp_id == ARB_ID_M1);
    assign m0_rdata  = m0_rvalid ? dc_rdata : '0;
    assign m1_rdata  = m1_rvalid ? dc_rdata : '0;
    assign m0_rhit   = m0_rvalid & dc_hit;
    assign m1_rhit   = m1_rvalid & dc_hit;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Bench for dcache_arbiter: directed vector table, reset sequences and random traffic
// checked against a cycle-level reference model with a simple fixed-latency cache model.
module tb_dcache_arbiter;
    import dcache_arbiter_pkg::*;

    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;
    localparam logic [31:0] RANGE_END = 32'h0000_4000;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_rhit;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [2:0]  m0_wsz;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_rhit;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [2:0]  m1_wsz;
    logic        dc_re, dc_we, dc_hit;
    logic [31:0] dc_raddr, dc_waddr, dc_wdata, dc_rdata;
    logic [2:0]  dc_wsz;

    dcache_arbiter #(
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wsz    (m0_wsz),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_rhit   (m0_rhit),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wsz    (m1_wsz),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_rhit   (m1_rhit),
        .dc_re     (dc_re),
        .dc_raddr  (dc_raddr),
        .dc_we     (dc_we),
        .dc_waddr  (dc_waddr),
        .dc_wdata  (dc_wdata),
        .dc_wsz    (dc_wsz),
        .dc_rdata  (dc_rdata),
        .dc_hit    (dc_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] defaultWord(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Cache model: two-stage read latency, out-of-range reads miss with zero data.
    logic [31:0] cache_mem [logic [31:0]];
    logic [31:0] c1_data, c2_data;
    logic        c1_hit, c2_hit;

    always @(posedge clk) begin : cache_model
        logic [31:0] rd;
        logic        hit;
        rd  = 32'hDEAD_BEEF;
        hit = 1'b1;
        if (dc_re) begin
            if (dc_raddr >= RANGE_END) begin
                rd  = '0;
                hit = 1'b0;
            end else if (cache_mem.exists(dc_raddr)) begin
                rd = cache_mem[dc_raddr];
            end else begin
                rd = defaultWord(dc_raddr);
            end
        end
        if (dc_we && dc_waddr < RANGE_END) cache_mem[dc_waddr] = dc_wdata;
        c1_data <= rd;
        c1_hit  <= hit;
        c2_data <= c1_data;
        c2_hit  <= c1_hit;
    end

    assign dc_rdata = c2_data;
    assign dc_hit   = c2_hit;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  wsz;
    } rq_t;

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] data;
        logic        hit;
    } rsp_t;

    typedef struct {
        logic r0, w0;
        logic [31:0] a0, d0;
        logic r1;
        logic [31:0] a1;
        logic g0, g1, v0;
        logic [31:0] q0;
        logic v1;
        logic [31:0] q1;
        logic h1;
    } vec_t;

    // Reference model state: grants are decided from the current requests and the rules alone.
    rsp_t        rsp_q [$];
    logic [31:0] ref_mem [logic [31:0]];
    int          m_cnt;
    bit          m_wr_last;
    int          cyc;
    int          n_checks;
    int          n_fail;

    function automatic void refRead(input logic [31:0] a, output logic [31:0] d, output logic h);
        if (a >= RANGE_END) begin
            d = '0;
            h = 1'b0;
        end else begin
            d = ref_mem.exists(a) ? ref_mem[a] : defaultWord(a);
            h = 1'b1;
        end
    endfunction

    function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0,
                                input logic r1, input logic [31:0] a1,
                                input logic g0, g1, v0, input logic [31:0] q0,
                                input logic v1, input logic [31:0] q1, input logic h1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.q0 = q0; v.v1 = v1; v.q1 = q1; v.h1 = h1;
        return v;
    endfunction

    function automatic rq_t randReq();
        rq_t r;
        r.req   = 1'b1;
        r.we    = ($urandom_range(0, 3) == 0);
        r.addr  = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 7) == 0) r.addr = r.addr + RANGE_END;
        r.wdata = $urandom;
        r.wsz   = 3'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input rq_t a, input rq_t b);
        m0_req = a.req; m0_we = a.we; m0_addr = a.addr; m0_wdata = a.wdata; m0_wsz = a.wsz;
        m1_req = b.req; m1_we = b.we; m1_addr = b.addr; m1_wdata = b.wdata; m1_wsz = b.wsz;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " m0_gnt"},    32'(m0_gnt),    '0);
        checkOutput({tag, " m1_gnt"},    32'(m1_gnt),    '0);
        checkOutput({tag, " dc_re"},     32'(dc_re),     '0);
        checkOutput({tag, " dc_raddr"},  dc_raddr,       '0);
        checkOutput({tag, " dc_we"},     32'(dc_we),     '0);
        checkOutput({tag, " dc_waddr"},  dc_waddr,       '0);
        checkOutput({tag, " dc_wdata"},  dc_wdata,       '0);
        checkOutput({tag, " dc_wsz"},    32'(dc_wsz),    '0);
        checkOutput({tag, " m0_rvalid"}, 32'(m0_rvalid), '0);
        checkOutput({tag, " m0_rdata"},  m0_rdata,       '0);
        checkOutput({tag, " m0_rhit"},   32'(m0_rhit),   '0);
        checkOutput({tag, " m1_rvalid"}, 32'(m1_rvalid), '0);
        checkOutput({tag, " m1_rdata"},  m1_rdata,       '0);
        checkOutput({tag, " m1_rhit"},   32'(m1_rhit),   '0);
    endtask

    task automatic modelReset();
        m_cnt     = 0;
        m_wr_last = 0;
        rsp_q.delete();
    endtask

    // Drives one cycle's requests, checks all outputs mid-cycle against the model, updates it.
    task automatic runCycle(input string tag, input rq_t a, input rq_t b,
                            output logic g0, output logic g1);
        logic        e0, e1, rd_g, wr_g, have, rh;
        logic [31:0] rd;
        rq_t         s;
        rsp_t        r;
        string       p;
        applyStimulus(a, b);
        #4;
        p  = $sformatf("%s c%0d", tag, cyc);
        e0 = a.req && (a.we || !m_wr_last);
        e1 = b.req && (b.we || !m_wr_last);
        g0 = 1'b0;
        g1 = 1'b0;
        if (e1 && m_cnt == STARVE_MAX) g1 = 1'b1;
        else if (e0) g0 = 1'b1;
        else if (e1) g1 = 1'b1;
        s    = g1 ? b : a;
        rd_g = (g0 || g1) && !s.we;
        wr_g = (g0 || g1) && s.we;
        checkOutput({p, " m0_gnt"},   32'(m0_gnt),   32'(g0));
        checkOutput({p, " m1_gnt"},   32'(m1_gnt),   32'(g1));
        checkOutput({p, " dc_re"},    32'(dc_re),    32'(rd_g));
        checkOutput({p, " dc_raddr"}, dc_raddr,      rd_g ? s.addr : 32'h0);
        checkOutput({p, " dc_we"},    32'(dc_we),    32'(wr_g));
        checkOutput({p, " dc_waddr"}, dc_waddr,      wr_g ? s.addr : 32'h0);
        checkOutput({p, " dc_wdata"}, dc_wdata,      wr_g ? s.wdata : 32'h0);
        checkOutput({p, " dc_wsz"},   32'(dc_wsz),   wr_g ? 32'(s.wsz) : 32'h0);
        have = 1'b0;
        r    = '{due: -1, id: 1'b0, data: 32'h0, hit: 1'b0};
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r    = rsp_q.pop_front();
            have = 1'b1;
        end
        checkOutput({p, " m0_rvalid"}, 32'(m0_rvalid), 32'(have && r.id == 1'b0));
        checkOutput({p, " m0_rdata"},  m0_rdata,       (have && r.id == 1'b0) ? r.data : 32'h0);
        checkOutput({p, " m0_rhit"},   32'(m0_rhit),   32'(have && r.id == 1'b0 && r.hit));
        checkOutput({p, " m1_rvalid"}, 32'(m1_rvalid), 32'(have && r.id == 1'b1));
        checkOutput({p, " m1_rdata"},  m1_rdata,       (have && r.id == 1'b1) ? r.data : 32'h0);
        checkOutput({p, " m1_rhit"},   32'(m1_rhit),   32'(have && r.id == 1'b1 && r.hit));
        if (rd_g) begin
            refRead(s.addr, rd, rh);
            rsp_q.push_back('{due: cyc + RD_LAT, id: g1, data: rd, hit: rh});
        end
        if (wr_g && s.addr < RANGE_END) ref_mem[s.addr] = s.wdata;
        m_wr_last = wr_g;
        if (!b.req || g1) m_cnt = 0;
        else if (m_cnt < STARVE_MAX) m_cnt++;
        cyc++;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [31];
    rq_t  idle_rq, ra, rb;
    logic g0, g1;
    bit   pend_a, pend_b;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        modelReset();
        cache_mem[32'h10] = 32'hA5A5_0001;
        ref_mem[32'h10]   = 32'hA5A5_0001;
        idle_rq = '0;

        // Directed vectors, one per cycle, expectations derived by hand.
        tbl[0]  = mk(1, 0, 32'h10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0001, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 32'h20, 32'h1122_3344, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 32'h20, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1122_3344, 0, 0, 0);
        tbl[9]  = mk(1, 0, 32'h30, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 32'h34, 0, 1, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 32'h38, 0, 0, 0, 1, 0, 1, 32'hC0DE_0030, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC0DE_0034, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC0DE_0038, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 32'h4000, 0, 1, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 17; i <= 30; i++) begin
            logic req, gm1, vm1, vm0;
            req = (i <= 28);
            gm1 = (i == 21) || (i == 26);
            vm1 = (i == 23) || (i == 28);
            vm0 = (i >= 19) && !vm1;
            tbl[i] = mk(req, 0, 32'h100, 0, req, 32'h200, req && !gm1, gm1,
                        vm0, vm0 ? 32'hC0DE_0100 : 32'h0, vm1, vm1 ? 32'hC0DE_0200 : 32'h0, vm1);
        end

        // Reset holds every output low even with live requests.
        rst_n = 1'b0;
        ra = '{req: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0, wsz: 3'd0};
        applyStimulus(ra, ra);
        #3;
        checkAllZero("por");
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(idle_rq, idle_rq);
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            ra = '{req: tbl[i].r0, we: tbl[i].w0, addr: tbl[i].a0, wdata: tbl[i].d0,
                   wsz: tbl[i].w0 ? ACCESS_SZ_WORD : 3'd0};
            rb = '{req: tbl[i].r1, we: 1'b0, addr: tbl[i].a1, wdata: 32'h0, wsz: 3'd0};
            runCycle("tbl", ra, rb, g0, g1);
            checkOutput($sformatf("tbl%0d m0_gnt", i),    32'(m0_gnt),    32'(tbl[i].g0));
            checkOutput($sformatf("tbl%0d m1_gnt", i),    32'(m1_gnt),    32'(tbl[i].g1));
            checkOutput($sformatf("tbl%0d m0_rvalid", i), 32'(m0_rvalid), 32'(tbl[i].v0));
            checkOutput($sformatf("tbl%0d m0_rdata", i),  m0_rdata,       tbl[i].q0);
            checkOutput($sformatf("tbl%0d m1_rvalid", i), 32'(m1_rvalid), 32'(tbl[i].v1));
            checkOutput($sformatf("tbl%0d m1_rdata", i),  m1_rdata,       tbl[i].q1);
            checkOutput($sformatf("tbl%0d m1_rhit", i),   32'(m1_rhit),   32'(tbl[i].h1));
            nextCycle();
        end

        // Build up starvation count and an in-flight read, then reset mid-cycle.
        ra = '{req: 1'b1, we: 1'b0, addr: 32'h40, wdata: 32'h0, wsz: 3'd0};
        rb = '{req: 1'b1, we: 1'b0, addr: 32'h44, wdata: 32'h0, wsz: 3'd0};
        runCycle("pre", ra, rb, g0, g1);
        nextCycle();
        runCycle("pre", '{req: 1'b1, we: 1'b1, addr: 32'h48, wdata: 32'hCAFE_0001,
                          wsz: ACCESS_SZ_HALF}, rb, g0, g1);
        nextCycle();
        runCycle("pre", ra, rb, g0, g1);
        nextCycle();
        runCycle("pre", ra, rb, g0, g1);
        nextCycle();
        applyStimulus(ra, rb);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("arst");
        modelReset();
        cyc++;
        nextCycle();
        applyStimulus(idle_rq, idle_rq);
        #1;
        checkAllZero("arst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            runCycle("post", idle_rq, idle_rq, g0, g1);
            nextCycle();
        end
        for (int i = 0; i < 6; i++) begin
            runCycle("post", ra, rb, g0, g1);
            checkOutput($sformatf("post%0d m1_gnt", i), 32'(m1_gnt), 32'(i == 4));
            nextCycle();
        end
        for (int i = 0; i < 2; i++) begin
            runCycle("post", idle_rq, idle_rq, g0, g1);
            nextCycle();
        end

        // Random traffic: requesters hold until granted, occasionally abandon.
        pend_a = 0;
        pend_b = 0;
        ra = idle_rq;
        rb = idle_rq;
        for (int k = 0; k < 400; k++) begin
            if (!pend_a && $urandom_range(0, 2) != 0) begin
                ra = randReq();
                pend_a = 1;
            end else if (pend_a && $urandom_range(0, 15) == 0) begin
                pend_a = 0;
            end
            if (!pend_b && $urandom_range(0, 2) != 0) begin
                rb = randReq();
                pend_b = 1;
            end else if (pend_b && $urandom_range(0, 15) == 0) begin
                pend_b = 0;
            end
            ra.req = pend_a;
            rb.req = pend_b;
            runCycle("rnd", ra, rb, g0, g1);
            if (g0) pend_a = 0;
            if (g1) pend_b = 0;
            nextCycle();
        end
        for (int i = 0; i < 4; i++) begin
            runCycle("drain", idle_rq, idle_rq, g0, g1);
            nextCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
